// File: rtl/conv_ctrl_pkg.sv
// Shared types for the 1-D convolution layer controller: FSM encoding and address-width helper.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    COMP  = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Never returns 0 so that a 2-entry memory still gets a 1-bit address.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_ctrl_cnt.sv
// Up-counter with clear priority over increment; o_tc flags LIMIT-1 and the count holds there.
module conv_ctrl_cnt
  import conv_ctrl_pkg::*;
#(
  parameter int LIMIT = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/conv_ctrl.sv
// Convolution layer controller: loads N words, sequences M taps per output, holds each result until accepted.
// Optional stall_cycles counter port enabled by defining CONV_CTRL_STALL_CNT_EN.
module conv_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int N  = 16,
  parameter int M  = 8,
  parameter int AW = addr_w(N),
  parameter int FW = addr_w(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  output logic          x_wr_en,
  output logic [AW-1:0] x_addr,
  output logic [FW-1:0] f_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          m_valid_y,
  input  logic          m_ready_y,
  output logic          busy
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rd_v;
  logic          r_rd_first;
  logic [AW-1:0] w_wcnt;
  logic [AW-1:0] w_k;
  logic [FW-1:0] w_m;
  logic          w_wcnt_tc;
  logic          w_k_tc;
  logic          w_m_tc;
  logic          w_in_hs;
  logic          w_out_hs;

  assign w_in_hs  = (r_state == LOAD) && s_valid_x;
  assign w_out_hs = (r_state == OUT) && m_ready_y;

  conv_ctrl_cnt #(.LIMIT(N), .W(AW)) u_wcnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_in_hs),
    .i_clr (w_in_hs && w_wcnt_tc),
    .o_cnt (w_wcnt),
    .o_tc  (w_wcnt_tc)
  );

  conv_ctrl_cnt #(.LIMIT(N - M + 1), .W(AW)) u_k (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_out_hs && !w_k_tc),
    .i_clr (w_out_hs && w_k_tc),
    .o_cnt (w_k),
    .o_tc  (w_k_tc)
  );

  // m parks at M-1 through FLUSH/OUT so the read addresses stay stable while the result waits.
  conv_ctrl_cnt #(.LIMIT(M), .W(FW)) u_m (
    .clk   (clk),
    .reset (reset),
    .i_inc ((r_state == COMP) && !w_m_tc),
    .i_clr (w_out_hs),
    .o_cnt (w_m),
    .o_tc  (w_m_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_in_hs && w_wcnt_tc) w_state_nxt = COMP;
      COMP:    if (w_m_tc) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = OUT;
      OUT:     if (m_ready_y) w_state_nxt = w_k_tc ? LOAD : COMP;
      default: w_state_nxt = LOAD;
    endcase
  end

  // Read flags trail the address by one cycle to line up with the synchronous memory read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= LOAD;
      r_rd_v     <= 1'b0;
      r_rd_first <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_v     <= (r_state == COMP);
      r_rd_first <= (r_state == COMP) && (w_m == '0);
    end
  end

  assign s_ready_x = (r_state == LOAD);
  assign x_wr_en   = w_in_hs;
  assign x_addr    = (r_state == LOAD) ? w_wcnt : (w_k + AW'(w_m));
  assign f_addr    = w_m;
  assign mac_en    = r_rd_v;
  assign mac_clr   = r_rd_first;
  assign m_valid_y = (r_state == OUT);
  assign busy      = (r_state != LOAD);

`ifdef CONV_CTRL_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if ((r_state == OUT) && !m_ready_y && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: expected write addresses and per-output tap lists are queued, a monitor checks them.
module tb_conv_ctrl;

  localparam int N  = 16;
  localparam int M  = 8;
  localparam int AW = 4;
  localparam int FW = 3;
  localparam int NOUT = N - M + 1;

  logic          clk;
  logic          reset;
  logic          s_valid_x;
  logic          s_ready_x;
  logic          x_wr_en;
  logic [AW-1:0] x_addr;
  logic [FW-1:0] f_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          m_valid_y;
  logic          m_ready_y;
  logic          busy;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   stall_base;
`endif

  conv_ctrl #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .x_wr_en   (x_wr_en),
    .x_addr    (x_addr),
    .f_addr    (f_addr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .busy      (busy)
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: words to be written and outputs (by k) still owed by the DUT
  int exp_wr[$];
  int exp_out[$];

  bit vgate = 0;
  bit mon_en = 0;
  int vmode = 0;
  int rmode = 0;

  int tap, clr_cnt, stall_run, last_acc, last_hs, k_done;
  bit prev_valid, rdy_due;
  logic [AW-1:0] prev_xa;
  logic [FW-1:0] prev_fa;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stimulus drivers, updated just after each rising edge
  initial begin
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_valid_x = vgate && ((vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      case (rmode)
        0:       m_ready_y = 1'b1;
        1:       m_ready_y = 1'($urandom_range(0, 1));
        default: m_ready_y = (stall_run >= 5);
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!mon_en) begin
      exp_wr.delete();
      exp_out.delete();
      tap = 0; clr_cnt = 0; stall_run = 0; last_acc = 0; last_hs = 0;
      prev_valid = 0; rdy_due = 0; prev_xa = '0; prev_fa = '0;
    end else begin
      check("busy_vs_ready", busy, !s_ready_x);
      check("wr_en", x_wr_en, s_valid_x & s_ready_x);
      if (rdy_due && cyc == last_hs + 1) begin
        check("ready_after_last_out", s_ready_x, 1);
        rdy_due = 0;
      end
      if (s_valid_x && s_ready_x) begin
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) check("wr_addr", x_addr, exp_wr.pop_front());
        last_acc = cyc;
      end
      if (mac_en) begin
        check("mac_expected", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) begin
          check("tap_x_addr", prev_xa, exp_out[0] + tap);
          check("tap_f_addr", prev_fa, tap);
          check("mac_clr_first_tap", mac_clr, tap == 0);
        end
        if (mac_clr) clr_cnt++;
        tap++;
      end else begin
        check("clr_without_en", mac_clr, 0);
      end
      if (m_valid_y) begin
        check("mac_en_in_out", mac_en, 0);
        check("out_expected", exp_out.size() != 0, 1);
        if (!prev_valid) begin
          check("taps_per_out", tap, M);
          if (exp_out.size() != 0 && exp_out[0] == 0)
            check("first_out_latency", cyc - last_acc, M + 2);
          else
            check("out_spacing", cyc - last_hs, M + 2);
`ifdef CONV_CTRL_STALL_CNT_EN
          stall_base = stall_cycles;
`endif
        end else begin
          check("hold_x_addr", x_addr, prev_xa);
          check("hold_f_addr", f_addr, prev_fa);
        end
        if (m_ready_y) begin
`ifdef CONV_CTRL_STALL_CNT_EN
          check("stall_cycles_delta", stall_cycles - stall_base, stall_run);
`endif
          if (exp_out.size() != 0) begin
            k_done = exp_out.pop_front();
            if (k_done == NOUT - 1) begin
              check("clr_per_vector", clr_cnt, NOUT);
              clr_cnt = 0;
              rdy_due = 1;
            end
          end
          tap = 0;
          stall_run = 0;
          last_hs = cyc;
        end else begin
          stall_run++;
        end
      end
      prev_valid = m_valid_y;
      prev_xa = x_addr;
      prev_fa = f_addr;
    end
  end

  task automatic push_vectors(input int nvec);
    for (int v = 0; v < nvec; v++) begin
      for (int i = 0; i < N; i++) exp_wr.push_back(i);
      for (int k = 0; k < NOUT; k++) exp_out.push_back(k);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_wr.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vgate = 0;
    while (exp_out.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("phase_within_budget", n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_phase(input int nvec, input int vm, input int rm);
    vmode = vm;
    rmode = rm;
    push_vectors(nvec);
    vgate = 1;
    wait_done(3000 * nvec);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready_x"}, s_ready_x, 1);
    check({tag, "_x_addr"}, x_addr, 0);
    check({tag, "_f_addr"}, f_addr, 0);
    check({tag, "_mac_en"}, mac_en, 0);
    check({tag, "_mac_clr"}, mac_clr, 0);
    check({tag, "_m_valid_y"}, m_valid_y, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x_wr_en"}, x_wr_en, 0);
`ifdef CONV_CTRL_STALL_CNT_EN
    check({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("in_reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    run_phase(2, 0, 0);   // streaming, no stalls
    run_phase(2, 1, 1);   // random valid and ready
    run_phase(1, 0, 2);   // every output stalled 5 cycles

    // abort a vector during COMP with a 2-cycle reset
    vmode = 0;
    rmode = 0;
    push_vectors(1);
    vgate = 1;
    begin
      int n;
      n = 0;
      while (exp_wr.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("abort_load_within_budget", n < 200, 1);
    end
    vgate = 0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", busy, 1);
    mon_en = 0;
    reset = 1'b0;
    #1;
    check("abort_m_valid_y", m_valid_y, 0);
    check("abort_s_ready_x", s_ready_x, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle("after_abort");
    @(posedge clk);
    #1;
    mon_en = 1;
    run_phase(1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
